// File: rtl/benes_burst_ctrl_pkg.sv
// Shared types for the Benes burst controller: datapath beat structs, AXI response codes, FSM states.
// Pure declarations; no latency or backpressure of its own.
package benes_burst_ctrl_pkg;

    localparam int BENES_LANES = 4;
    localparam int LANE_W      = 16;
    localparam int SEL_W       = 2 * BENES_LANES;

    // Each output lane i takes input lane sel[2i+:2].
    typedef struct packed {
        logic [SEL_W-1:0]                  sel;
        logic [BENES_LANES-1:0][LANE_W-1:0] lane;
    } IntcBenesInputs;

    typedef struct packed {
        logic [BENES_LANES-1:0][LANE_W-1:0] lane;
    } IntcBenesOutputs;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

endpackage

// File: rtl/benes_out_fifo.sv
// First-word fall-through FIFO of Benes results; a write is visible at the head the cycle after it lands.
// No backpressure on the write side: the caller's credit scheme keeps it from ever overflowing.
module benes_out_fifo
    import benes_burst_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wr_en_i,
    input  IntcBenesOutputs wr_dat_i,
    input  logic            rd_en_i,
    output IntcBenesOutputs rd_dat_o,
    output logic            empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    IntcBenesOutputs  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    // A pop frees the slot in the same cycle, so push-at-full with pop is fine.
    assign do_rd = rd_en_i && (count_q != '0);
    assign do_wr = wr_en_i && ((count_q != FULL_CNT) || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;

    assert property (@(posedge clk_i) disable iff (rst_i)
        !(wr_en_i && (count_q == FULL_CNT) && !rd_en_i));

endmodule

// File: rtl/benes_burst_ctrl.sv
// AXI4 burst front end for the Benes core: W beats stream into the core, results queue in a FWFT FIFO served to AR/R.
// wready is withheld whenever stored + in-flight results would exceed the FIFO, so the core never needs backpressure.
module benes_burst_ctrl
    import benes_burst_ctrl_pkg::*;
#(
    parameter int ID_W  = 1,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             s00_axi_aclk,
    input  logic             s00_axi_areset,
    input  logic [ID_W-1:0]  awid,
    input  logic [7:0]       awlen,
    input  logic             awvalid,
    output logic             awready,
    input  IntcBenesInputs   wdata,
    input  logic             wlast,
    input  logic             wvalid,
    output logic             wready,
    output logic [ID_W-1:0]  bid,
    output logic [1:0]       bresp,
    output logic             bvalid,
    input  logic             bready,
    input  logic [ID_W-1:0]  arid,
    input  logic [7:0]       arlen,
    input  logic             arvalid,
    output logic             arready,
    output logic [ID_W-1:0]  rid,
    output IntcBenesOutputs  rdata,
    output logic [1:0]       rresp,
    output logic             rlast,
    output logic             rvalid,
    input  logic             rready,
    output logic             benes_in_valid,
    output IntcBenesInputs   benes_in_data,
    input  logic             benes_out_valid,
    input  IntcBenesOutputs  benes_out_data,
    output logic [CNT_W-1:0] fifo_count
);
    wr_state_e        wr_state_q, wr_state_d;
    logic [ID_W-1:0]  awid_q, awid_d;
    logic [7:0]       awlen_q, awlen_d;
    logic [7:0]       wbeat_q, wbeat_d;
    logic             werr_q, werr_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    rd_state_e        rd_state_q, rd_state_d;
    logic [ID_W-1:0]  arid_q, arid_d;
    logic [7:0]       arlen_q, arlen_d;
    logic [7:0]       rbeat_q, rbeat_d;

    logic [CNT_W:0]   credit_used;
    logic             has_credit, w_push, w_final, res_ok, r_pop, fifo_empty;

    // Depends only on registers, so wready never combinationally follows wvalid.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign has_credit  = credit_used < (CNT_W+1)'(DEPTH);
    assign w_push      = wvalid && wready;
    assign w_final     = (wbeat_q == awlen_q);
    assign res_ok      = benes_out_valid && (inflight_q != '0);
    assign r_pop       = rvalid && rready;

    assign benes_in_valid = w_push;
    assign benes_in_data  = wdata;
    assign inflight_d     = inflight_q + CNT_W'(w_push) - CNT_W'(res_ok);

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wr_state_q <= W_IDLE;
            awid_q     <= '0;
            awlen_q    <= '0;
            wbeat_q    <= '0;
            werr_q     <= 1'b0;
            inflight_q <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            awid_q     <= awid_d;
            awlen_q    <= awlen_d;
            wbeat_q    <= wbeat_d;
            werr_q     <= werr_d;
            inflight_q <= inflight_d;
        end
    end

    // The burst length comes from awlen; wlast is only cross-checked.
    always_comb begin
        wr_state_d = wr_state_q;
        awid_d     = awid_q;
        awlen_d    = awlen_q;
        wbeat_d    = wbeat_q;
        werr_d     = werr_q;
        case (wr_state_q)
            W_IDLE: if (awvalid) begin
                awid_d     = awid;
                awlen_d    = awlen;
                wbeat_d    = '0;
                werr_d     = 1'b0;
                wr_state_d = W_DATA;
            end
            W_DATA: if (w_push) begin
                wbeat_d = wbeat_q + 8'd1;
                if (wlast != w_final) werr_d = 1'b1;
                if (w_final) wr_state_d = W_RESP;
            end
            W_RESP: if (bready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = AXI_RESP_OKAY;
        case (wr_state_q)
            W_IDLE: awready = 1'b1;
            W_DATA: wready  = has_credit;
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = werr_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
            default: ;
        endcase
    end

    assign bid = awid_q;

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            rd_state_q <= R_IDLE;
            arid_q     <= '0;
            arlen_q    <= '0;
            rbeat_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            arid_q     <= arid_d;
            arlen_q    <= arlen_d;
            rbeat_q    <= rbeat_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arid_d     = arid_q;
        arlen_d    = arlen_q;
        rbeat_d    = rbeat_q;
        case (rd_state_q)
            R_IDLE: if (arvalid) begin
                arid_d     = arid;
                arlen_d    = arlen;
                rbeat_d    = '0;
                rd_state_d = R_DATA;
            end
            R_DATA: if (r_pop) begin
                rbeat_d = rbeat_q + 8'd1;
                if (rbeat_q == arlen_q) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // An empty FIFO mid-burst simply holds rvalid low until results land.
    always_comb begin
        arready = 1'b0;
        rvalid  = 1'b0;
        case (rd_state_q)
            R_IDLE:  arready = 1'b1;
            R_DATA:  rvalid  = !fifo_empty;
            default: ;
        endcase
    end

    assign rlast = rvalid && (rbeat_q == arlen_q);
    assign rid   = arid_q;
    assign rresp = AXI_RESP_OKAY;

    benes_out_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_out_fifo (
        .clk_i    (s00_axi_aclk),
        .rst_i    (s00_axi_areset),
        .wr_en_i  (res_ok),
        .wr_dat_i (benes_out_data),
        .rd_en_i  (r_pop),
        .rd_dat_o (rdata),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

endmodule
